// File: rtl/opc5_pkg.sv
// Shared definitions for the OPC5 boot loader: FSM state encodings,
// the frame magic word and the stream/bus word width.
package opc5_pkg;

    localparam int          WORD_W     = 16;
    localparam logic [15:0] BOOT_MAGIC = 16'h0C55;

    typedef enum logic [2:0] {
        S_MAGIC = 3'd0,
        S_BASE  = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_HOLD  = 3'd5,
        S_RUN   = 3'd6,
        S_ERROR = 3'd7
    } boot_state_t;

    // Stream handshake is open only while a frame is being received.
    function automatic logic state_accepts(input boot_state_t st);
        logic acc;
        case (st)
            S_MAGIC, S_BASE, S_COUNT, S_DATA, S_CSUM: acc = 1'b1;
            default:                                  acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/opc5_boot_loader_if.sv
// Stream-in and memory-write signals of the OPC5 boot loader.
//   in_valid/in_data/in_ready : 16-bit valid/ready program stream
//   mem_address/mem_data/mem_we : loader write port onto the memory bus
// slave  : loader side (consumes stream, drives memory writes)
// master : environment side (drives stream, observes memory writes)
interface opc5_boot_loader_if;
    import opc5_pkg::*;

    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic [WORD_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_data;
    logic              mem_we;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_address, mem_data, mem_we
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_address, mem_data, mem_we
    );
endinterface

// File: rtl/opc5_boot_hold_counter.sv
// Loadable 8-bit down-counter with a registered done flag; times how long
// the CPU is held in reset after the loader releases the memory bus.
//   clk, reset_b : clock, asynchronous active-low reset
//   load_i       : load load_val_i (has priority over en_i)
//   load_val_i   : value to load
//   en_i         : decrement by one while non-zero
//   done_o       : counter is zero
module opc5_boot_hold_counter (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic       done_o
);

    logic [7:0] count_q, count_d;
    logic       done_q;

    // Next count: load, decrement (saturating at zero) or hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter and done flag registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count_q <= 8'd0;
            done_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            done_q  <= (count_d == 8'd0);
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/opc5_boot_loader.sv
// OPC5 boot loader: holds the CPU in reset and owns the memory bus while a
// framed image (MAGIC, base, count N, N payload words, checksum) arrives on
// the stream; writes each payload word to base+index, verifies the 16-bit
// additive checksum, then releases the bus and, HOLD_CYCLES later, the CPU.
//   clk, reset_b : clock, asynchronous active-low reset
//   bus          : stream input and memory write port (slave modport)
//   reload_req   : restart loading (acted on only in RUN and ERROR)
//   bus_owner    : 1 = loader drives the memory bus
//   cpu_reset_b  : active-low CPU reset
//   busy         : loading or holding
//   error        : magic or checksum failure
module opc5_boot_loader
    import opc5_pkg::*;
#(
    parameter logic [15:0] MAGIC       = BOOT_MAGIC,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_b,
    opc5_boot_loader_if.slave         bus,
    input  logic                      reload_req,
    output logic                      bus_owner,
    output logic                      cpu_reset_b,
    output logic                      busy,
    output logic                      error
);

    boot_state_t       state_q, state_d;
    logic [WORD_W-1:0] base_q, base_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic [WORD_W-1:0] index_q, index_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic [WORD_W-1:0] mem_address_q, mem_address_d;
    logic [WORD_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              in_ready_q, in_ready_d;
    logic              bus_owner_q, bus_owner_d;
    logic              cpu_reset_b_q, cpu_reset_b_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;

    logic              accept_s;
    logic [WORD_W-1:0] index_nxt_s;
    logic              hold_load_s;
    logic              hold_en_s;
    logic              hold_done_s;

    assign accept_s    = bus.in_valid & in_ready_q;
    assign index_nxt_s = index_q + 16'd1;

    opc5_boot_hold_counter u_hold (
        .clk        (clk),
        .reset_b    (reset_b),
        .load_i     (hold_load_s),
        .load_val_i (8'(HOLD_CYCLES)),
        .en_i       (hold_en_s),
        .done_o     (hold_done_s)
    );

    // Frame parser: next state, frame registers and the write stage.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        count_d       = count_q;
        index_d       = index_q;
        sum_d         = sum_q;
        mem_we_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        hold_load_s   = 1'b0;
        hold_en_s     = 1'b0;
        case (state_q)
            S_MAGIC: begin
                if (accept_s) begin
                    state_d = (bus.in_data == MAGIC) ? S_BASE : S_ERROR;
                end else begin
                    state_d = S_MAGIC;
                end
            end
            S_BASE: begin
                if (accept_s) begin
                    base_d  = bus.in_data;
                    state_d = S_COUNT;
                end else begin
                    state_d = S_BASE;
                end
            end
            S_COUNT: begin
                if (accept_s) begin
                    count_d = bus.in_data;
                    index_d = 16'd0;
                    sum_d   = 16'd0;
                    state_d = (bus.in_data == 16'd0) ? S_CSUM : S_DATA;
                end else begin
                    state_d = S_COUNT;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    // Write lands one cycle after acceptance; address wraps mod 2^16.
                    mem_we_d      = 1'b1;
                    mem_address_d = base_q + index_q;
                    mem_data_d    = bus.in_data;
                    index_d       = index_nxt_s;
                    sum_d         = sum_q + bus.in_data;
                    state_d       = (index_nxt_s == count_q) ? S_CSUM : S_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (accept_s) begin
                    if (bus.in_data == sum_q) begin
                        state_d     = S_HOLD;
                        hold_load_s = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_HOLD: begin
                if (hold_done_s) begin
                    state_d = S_RUN;
                end else begin
                    hold_en_s = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_RUN, S_ERROR: begin
                if (reload_req) begin
                    state_d = S_MAGIC;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they register
    // in step with the state transition.
    always_comb begin
        in_ready_d    = state_accepts(state_d);
        bus_owner_d   = 1'b1;
        cpu_reset_b_d = 1'b0;
        busy_d        = 1'b1;
        error_d       = 1'b0;
        case (state_d)
            S_HOLD: begin
                bus_owner_d = 1'b0;
            end
            S_RUN: begin
                bus_owner_d   = 1'b0;
                cpu_reset_b_d = 1'b1;
                busy_d        = 1'b0;
            end
            S_ERROR: begin
                busy_d  = 1'b0;
                error_d = 1'b1;
            end
            default: begin
                bus_owner_d = 1'b1;
            end
        endcase
    end

    // State, frame and output registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q       <= S_MAGIC;
            base_q        <= 16'd0;
            count_q       <= 16'd0;
            index_q       <= 16'd0;
            sum_q         <= 16'd0;
            mem_we_q      <= 1'b0;
            mem_address_q <= 16'd0;
            mem_data_q    <= 16'd0;
            in_ready_q    <= 1'b0;
            bus_owner_q   <= 1'b1;
            cpu_reset_b_q <= 1'b0;
            busy_q        <= 1'b1;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            count_q       <= count_d;
            index_q       <= index_d;
            sum_q         <= sum_d;
            mem_we_q      <= mem_we_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            in_ready_q    <= in_ready_d;
            bus_owner_q   <= bus_owner_d;
            cpu_reset_b_q <= cpu_reset_b_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus_owner       = bus_owner_q;
    assign cpu_reset_b     = cpu_reset_b_q;
    assign busy            = busy_q;
    assign error           = error_q;

endmodule

// File: tb/tb_opc5_boot_loader.sv
// Directed bench for opc5_boot_loader: streams hand-built frames and
// checks memory writes, bus hand-over, CPU reset timing and error paths.
module tb_opc5_boot_loader;

    logic clk;
    logic reset_b;
    logic reload_req;
    logic bus_owner;
    logic cpu_reset_b;
    logic busy;
    logic error;

    opc5_boot_loader_if tb_if ();

    opc5_boot_loader #(.HOLD_CYCLES(4)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .bus         (tb_if),
        .reload_req  (reload_req),
        .bus_owner   (bus_owner),
        .cpu_reset_b (cpu_reset_b),
        .busy        (busy),
        .error       (error)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int we_viol   = 0;

    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    logic [15:0] fr[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (tb_if.mem_we) begin
            wa_q.push_back(tb_if.mem_address);
            wd_q.push_back(tb_if.mem_data);
            wc_q.push_back(cyc);
            if (!bus_owner) we_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic check_write(input int i, input logic [15:0] a, input logic [15:0] d);
        if (i < wa_q.size()) begin
            chk($sformatf("wr%0d_addr", i), {16'd0, wa_q[i]}, {16'd0, a});
            chk($sformatf("wr%0d_data", i), {16'd0, wd_q[i]}, {16'd0, d});
        end else begin
            chk($sformatf("wr%0d_missing", i), 32'd0, 32'd1);
        end
    endtask

    // Present one word and wait (bounded) for it to be accepted.
    task automatic send(input logic [15:0] w);
        int n;
        @(negedge clk);
        tb_if.in_valid = 1'b1;
        tb_if.in_data  = w;
        n = 0;
        while (!tb_if.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tb_if.in_ready) begin
            chk("handshake_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int gap);
        @(negedge clk);
        tb_if.in_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // Stream fr[]; with gap>0, in_valid drops for gap cycles between payload words.
    task automatic load_frame(input int gap);
        clear_writes();
        for (int i = 0; i < fr.size(); i++) begin
            send(fr[i]);
            if (gap > 0 && i >= 3 && i < fr.size() - 1) idle(gap);
        end
        tb_if.in_valid = 1'b0;
    endtask

    // After an accepted checksum: bus released now, CPU reset released 5 edges later.
    task automatic expect_run(input string tag);
        chk({tag, "_owner_rel"}, {31'd0, bus_owner}, 32'd0);
        chk({tag, "_cpu_held"}, {31'd0, cpu_reset_b}, 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_cpu_still_held"}, {31'd0, cpu_reset_b}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_cpu_rel"}, {31'd0, cpu_reset_b}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, error}, 32'd0);
        chk({tag, "_ready"}, {31'd0, tb_if.in_ready}, 32'd0);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload_req = 1'b1;
        @(posedge clk);
        #1;
        reload_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset_b        = 1'b0;
        reload_req     = 1'b0;
        tb_if.in_valid = 1'b0;
        tb_if.in_data  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, tb_if.in_ready}, 32'd0);
        chk("rst_we", {31'd0, tb_if.mem_we}, 32'd0);
        chk("rst_owner", {31'd0, bus_owner}, 32'd1);
        chk("rst_cpu", {31'd0, cpu_reset_b}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_err", {31'd0, error}, 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, tb_if.in_ready}, 32'd1);

        // Basic back-to-back frame.
        fr = '{16'h0C55, 16'h0000, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6666};
        load_frame(0);
        chk("f1_nwr", wa_q.size(), 32'd3);
        check_write(0, 16'h0000, 16'h1111);
        check_write(1, 16'h0001, 16'h2222);
        check_write(2, 16'h0002, 16'h3333);
        if (wc_q.size() == 3) begin
            chk("f1_b2b_01", wc_q[1] - wc_q[0], 32'd1);
            chk("f1_b2b_12", wc_q[2] - wc_q[1], 32'd1);
        end
        expect_run("f1");

        // Reload from RUN re-asserts CPU reset on the next edge.
        pulse_reload();
        chk("rl_run_cpu", {31'd0, cpu_reset_b}, 32'd0);
        chk("rl_run_owner", {31'd0, bus_owner}, 32'd1);
        chk("rl_run_ready", {31'd0, tb_if.in_ready}, 32'd1);

        // Bad magic.
        clear_writes();
        send(16'h1234);
        tb_if.in_valid = 1'b0;
        chk("magic_err", {31'd0, error}, 32'd1);
        chk("magic_ready", {31'd0, tb_if.in_ready}, 32'd0);
        chk("magic_owner", {31'd0, bus_owner}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("magic_err_stays", {31'd0, error}, 32'd1);
        chk("magic_nwr", wa_q.size(), 32'd0);

        // Reload from ERROR, then a frame wrapping the address space.
        pulse_reload();
        chk("rl_err_clear", {31'd0, error}, 32'd0);
        chk("rl_err_ready", {31'd0, tb_if.in_ready}, 32'd1);
        fr = '{16'h0C55, 16'hFFFE, 16'h0003, 16'h000A, 16'h000B, 16'h000C, 16'h0021};
        load_frame(0);
        chk("wrap_nwr", wa_q.size(), 32'd3);
        check_write(0, 16'hFFFE, 16'h000A);
        check_write(1, 16'hFFFF, 16'h000B);
        check_write(2, 16'h0000, 16'h000C);
        expect_run("wrap");

        // Checksum mismatch.
        pulse_reload();
        fr = '{16'h0C55, 16'h0040, 16'h0001, 16'h0001, 16'h0000};
        load_frame(0);
        chk("cs_nwr", wa_q.size(), 32'd1);
        chk("cs_err", {31'd0, error}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("cs_cpu", {31'd0, cpu_reset_b}, 32'd0);
        chk("cs_owner", {31'd0, bus_owner}, 32'd1);

        // Empty payload.
        pulse_reload();
        fr = '{16'h0C55, 16'h0100, 16'h0000, 16'h0000};
        load_frame(0);
        expect_run("empty");
        chk("empty_nwr", wa_q.size(), 32'd0);

        // Stalled payload: one idle cycle between data words.
        pulse_reload();
        fr = '{16'h0C55, 16'h0200, 16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A};
        load_frame(1);
        chk("stall_nwr", wa_q.size(), 32'd4);
        check_write(0, 16'h0200, 16'h0001);
        check_write(1, 16'h0201, 16'h0002);
        check_write(2, 16'h0202, 16'h0003);
        check_write(3, 16'h0203, 16'h0004);
        expect_run("stall");

        // Asynchronous reset in the middle of the payload.
        pulse_reload();
        send(16'h0C55);
        send(16'h0300);
        send(16'h0005);
        send(16'hAAAA);
        send(16'hBBBB);
        #2;
        reset_b = 1'b0;
        #1;
        chk("arst_we", {31'd0, tb_if.mem_we}, 32'd0);
        chk("arst_addr", {16'd0, tb_if.mem_address}, 32'd0);
        chk("arst_data", {16'd0, tb_if.mem_data}, 32'd0);
        chk("arst_ready", {31'd0, tb_if.in_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd1);
        tb_if.in_valid = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        fr = '{16'h0C55, 16'h0010, 16'h0002, 16'h0005, 16'h0007, 16'h000C};
        load_frame(0);
        chk("post_rst_nwr", wa_q.size(), 32'd2);
        check_write(0, 16'h0010, 16'h0005);
        check_write(1, 16'h0011, 16'h0007);
        expect_run("post_rst");

        chk("we_without_owner", we_viol, 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
